// File: rtl/float_sum_reduce.sv
// float_sum_reduce: streaming packet-sum front-end for float_add_pipeline.
// Elements are buffered in a small skid FIFO, then folded one at a time into
// an accumulator via the external adder's req/ack handshake. The packet sum
// and element count are presented on a valid/ready output.
module float_sum_reduce #(
    parameter int float_width = 32,
    parameter int fifo_depth  = 4,
    parameter int count_width = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [float_width-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [float_width-1:0] out_data,
    output logic [count_width-1:0] out_count,
    output logic                   add_req,
    output logic [float_width-1:0] add_a,
    output logic [float_width-1:0] add_b,
    input  logic [float_width-1:0] add_out,
    input  logic                   add_ack,
    output logic                   protocol_err
);
    localparam int ptr_w = $clog2(fifo_depth);

    typedef enum logic [1:0] {ST_FIRST, ST_ACCUM, ST_WAIT, ST_DONE} state_t;

    // FIFO storage: {last, data}; pointers carry one extra wrap bit.
    logic [float_width:0]   mem_q [fifo_depth];
    logic [ptr_w:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ptr_w:0]         occ_d;
    logic                   in_ready_q, in_ready_d;
    logic                   push, pop, fifo_empty;
    logic [float_width-1:0] head_data;
    logic                   head_last;

    state_t                 state_q, state_d;
    logic [float_width-1:0] acc_q, acc_d;
    logic [count_width-1:0] count_q, count_d;
    logic                   pend_last_q, pend_last_d;
    logic                   add_req_q, add_req_d;
    logic [float_width-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
    logic                   out_valid_q, out_valid_d;
    logic [float_width-1:0] out_data_q, out_data_d;
    logic [count_width-1:0] out_count_q, out_count_d;
    logic                   err_q, err_d;

    function automatic logic [count_width-1:0] sat_inc(input logic [count_width-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    assign push       = in_valid & in_ready_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign head_data  = mem_q[rd_ptr_q[ptr_w-1:0]][float_width-1:0];
    assign head_last  = mem_q[rd_ptr_q[ptr_w-1:0]][float_width];

    // Sequencer: decide pops, adder requests and output updates for this cycle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        pend_last_d = pend_last_q;
        add_req_d   = 1'b0;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        err_d       = err_q | (add_ack & (state_q != ST_WAIT));
        pop         = 1'b0;
        case (state_q)
            ST_FIRST: begin
                // First element is loaded directly so a lone element passes bit-exact.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    acc_d   = head_data;
                    count_d = count_width'(1);
                    if (head_last) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = head_data;
                        out_count_d = count_width'(1);
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    add_req_d   = 1'b1;
                    add_a_d     = acc_q;
                    add_b_d     = head_data;
                    pend_last_d = head_last;
                    count_d     = sat_inc(count_q);
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (add_ack) begin
                    acc_d = add_out;
                    if (pend_last_q) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = add_out;
                        out_count_d = count_q;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_FIRST;
                end
            end
            default: state_d = ST_FIRST;
        endcase
    end

    // FIFO pointer update; in_ready is registered from next-cycle occupancy.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{ptr_w{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{ptr_w{1'b0}}, pop};
        occ_d      = wr_ptr_d - rd_ptr_d;
        in_ready_d = (occ_d != (ptr_w + 1)'(fifo_depth));
    end

    // FIFO storage write (data path, no reset needed).
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ptr_w-1:0]] <= {in_last, in_data};
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b0;
            state_q     <= ST_FIRST;
            acc_q       <= '0;
            count_q     <= '0;
            pend_last_q <= 1'b0;
            add_req_q   <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            pend_last_q <= pend_last_d;
            add_req_q   <= add_req_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            err_q       <= err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign add_req      = add_req_q;
    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_count    = out_count_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_float_sum_reduce.sv
// Directed bench for float_sum_reduce with a table-driven stand-in adder.
module tb_float_sum_reduce;
    localparam logic [31:0] F_1   = 32'h3F800000;
    localparam logic [31:0] F_M1  = 32'hBF800000;
    localparam logic [31:0] F_2   = 32'h40000000;
    localparam logic [31:0] F_3   = 32'h40400000;
    localparam logic [31:0] F_4   = 32'h40800000;
    localparam logic [31:0] F_5   = 32'h40A00000;
    localparam logic [31:0] F_6   = 32'h40C00000;
    localparam logic [31:0] F_PI  = 32'h40490FDB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        add_req;
    logic [31:0] add_a, add_b;
    logic [31:0] add_out = '0;
    logic        add_ack;
    logic        protocol_err;

    logic        model_ack = 1'b0;
    logic        inj_ack = 1'b0;
    logic        stall = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    int          req_cnt = 0;

    assign add_ack = model_ack | inj_ack;

    always #5 clk = ~clk;

    float_sum_reduce #(.float_width(32), .fifo_depth(4), .count_width(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .add_req(add_req), .add_a(add_a), .add_b(add_b), .add_out(add_out), .add_ack(add_ack),
        .protocol_err(protocol_err)
    );

    // Hand-computed single-precision sums for every operand pair the vectors use.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {F_1, F_2}:  return F_3;
            {F_3, F_3}:  return F_6;
            {F_1, F_M1}: return 32'h00000000;
            {F_1, F_1}:  return F_2;
            {F_2, F_1}:  return F_3;
            {F_3, F_1}:  return F_4;
            {F_4, F_1}:  return F_5;
            {F_5, F_1}:  return F_6;
            {F_2, F_2}:  return F_4;
            default:     return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        logic rdy;
        int   n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            rdy = in_ready;
            tick();
            n++;
        end while (!rdy && n < 100);
        in_valid = 1'b0;
        if (!rdy) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        if (!out_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_out(input string tag, input logic [31:0] exp_d, input logic [15:0] exp_c);
        wait_valid(tag);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_count"}, 32'(out_count), 32'(exp_c));
        tick();
    endtask

    // Adder stand-in: latency 2 after the request is seen, held off while stall is set.
    initial begin
        logic        pend;
        int          dly;
        logic [31:0] op_a, op_b;
        pend = 1'b0;
        dly  = 0;
        op_a = '0;
        op_b = '0;
        forever begin
            @(posedge clk);
            #1;
            model_ack = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                if (dly != 0) dly--;
                else if (!stall) begin
                    model_ack = 1'b1;
                    add_out   = fadd(op_a, op_b);
                    pend      = 1'b0;
                end
            end
            if (rst_n && add_req) begin
                pend = 1'b1;
                op_a = add_a;
                op_b = add_b;
                dly  = 1;
                req_cnt++;
            end
        end
    end

    initial begin
        int          r0;
        int          n;
        logic        stable;
        logic [31:0] snap_d;
        logic [15:0] snap_c;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_add_req", add_req, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_err", protocol_err, 0);
        rst_n = 1'b1;
        tick();

        // 1.0 + 2.0 + 3.0
        r0 = req_cnt;
        send(F_1, 1'b0);
        send(F_2, 1'b0);
        send(F_3, 1'b1);
        wait_out("t1", F_6, 16'd3);
        chk("t1_reqs", 32'(req_cnt - r0), 32'd2);

        // single element passes through untouched
        r0 = req_cnt;
        send(F_PI, 1'b1);
        wait_out("t2", F_PI, 16'd1);
        chk("t2_reqs", 32'(req_cnt - r0), 32'd0);

        // 1.0 + -1.0
        send(F_1, 1'b0);
        send(F_M1, 1'b1);
        wait_out("t3", 32'h00000000, 16'd2);

        // adder stalled: six elements fill accumulator, adder and four FIFO slots
        stall = 1'b1;
        r0 = req_cnt;
        for (int i = 0; i < 6; i++) send(F_1, (i == 5));
        repeat (3) tick();
        chk("t4_in_ready_full", in_ready, 0);
        chk("t4_one_in_flight", 32'(req_cnt - r0), 32'd1);
        chk("t4_no_out", out_valid, 0);
        stall = 1'b0;
        wait_out("t4", F_6, 16'd6);
        chk("t4_reqs", 32'(req_cnt - r0), 32'd5);

        // output backpressure with next packet buffered behind it
        out_ready = 1'b0;
        send(F_1, 1'b0);
        send(F_2, 1'b1);
        wait_valid("t4b_first");
        snap_d = out_data;
        snap_c = out_count;
        chk("t4b_first_data", snap_d, F_3);
        chk("t4b_first_count", 32'(snap_c), 32'd2);
        r0 = req_cnt;
        stable = 1'b1;
        send(F_3, 1'b0);
        send(F_3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b1 || out_data !== snap_d || out_count !== snap_c) stable = 1'b0;
            tick();
        end
        chk("t4b_stable", stable, 1);
        chk("t4b_held_reqs", 32'(req_cnt - r0), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("t4b_dropped", out_valid, 0);
        wait_out("t4b_second", F_6, 16'd2);

        // reset while waiting on the adder
        stall = 1'b1;
        r0 = req_cnt;
        send(F_1, 1'b0);
        send(F_2, 1'b1);
        n = 0;
        while (req_cnt == r0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk("t5_in_wait", 32'(req_cnt - r0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_add_req", add_req, 0);
        chk("t5_add_a", add_a, 0);
        chk("t5_add_b", add_b, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_data", out_data, 0);
        chk("t5_out_count", 32'(out_count), 0);
        chk("t5_in_ready", in_ready, 0);
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(F_2, 1'b0);
        send(F_2, 1'b1);
        wait_out("t5", F_4, 16'd2);
        chk("t5_err", protocol_err, 0);

        // stray ack while holding a result
        out_ready = 1'b0;
        send(F_PI, 1'b1);
        wait_valid("t6");
        inj_ack = 1'b1;
        tick();
        inj_ack = 1'b0;
        chk("t6_err_set", protocol_err, 1);
        chk("t6_data_kept", out_data, F_PI);
        chk("t6_count_kept", 32'(out_count), 32'd1);
        chk("t6_valid_kept", out_valid, 1);
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        chk("t6_accepted", out_valid, 0);
        repeat (2) tick();
        chk("t6_err_sticky", protocol_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
